// File: rtl/img_rsz_pkg.sv
// Shared constants, bus typedefs and helper functions for the block-averaging down-scaler.
package ImgRszPkg;

  localparam int unsigned PXL_PRIM_COLOR_NUM   = 3;
  localparam int unsigned PXL_PRIM_COLOR_W     = 8;
  localparam int unsigned IMG_WIDTH_IDX_W      = 11;
  localparam int unsigned IMG_HEIGHT_IDX_W     = 11;
  localparam int unsigned RSZ_IMG_WIDTH_SIZE   = 8;
  localparam int unsigned RSZ_IMG_HEIGHT_SIZE  = 4;
  localparam int unsigned RSZ_IMG_WIDTH_IDX_W  = 3;
  localparam int unsigned RSZ_IMG_HEIGHT_IDX_W = 2;
  localparam int unsigned RSZ_ACC_W            = PXL_PRIM_COLOR_W + IMG_WIDTH_IDX_W + IMG_HEIGHT_IDX_W;
  localparam int unsigned OUT_FIFO_DEPTH       = 8;
  localparam int unsigned OUT_FIFO_PTR_W       = 3;
  localparam int unsigned RSZ_SHIFT_W          = 4;

  typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;
  typedef logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0]
                [PXL_PRIM_COLOR_NUM-1:0][RSZ_ACC_W-1:0] FcRszPxlBuf_t;

  // One queued output pixel.
  typedef struct packed {
    FcRszPxlData_t                   data;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  x;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] y;
  } rsz_fifo_entry_t;

  // Index of the highest set bit (floor log2); 0 for a zero input.
  function automatic logic [RSZ_SHIFT_W-1:0] msb_idx(input logic [IMG_WIDTH_IDX_W-1:0] v);
    logic [RSZ_SHIFT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(IMG_WIDTH_IDX_W); i++) begin
      if (v[i]) idx = RSZ_SHIFT_W'(i);
    end
    return idx;
  endfunction

  // log2 of the block edge: floor log2 of the dimension minus log2 of the output size.
  function automatic logic [RSZ_SHIFT_W-1:0] blk_shift(input logic [IMG_WIDTH_IDX_W-1:0] dim,
                                                       input logic [RSZ_SHIFT_W-1:0]     out_idx_w);
    logic [RSZ_SHIFT_W-1:0] msb;
    msb = msb_idx(dim);
    return (msb >= out_idx_w) ? (msb - out_idx_w) : '0;
  endfunction

endpackage

// File: rtl/img_rsz_fifo.sv
// Synchronous FIFO of resized pixels {data, x, y}.
//  clk/rst     : clock, async active-high reset
//  push/pop    : write / read strobes (ignored when full / empty)
//  push_data   : entry to write
//  head_c      : entry at the read pointer
//  full_c/empty_c : occupancy flags
module img_rsz_fifo
  import ImgRszPkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  rsz_fifo_entry_t push_data,
  input  logic            pop,
  output rsz_fifo_entry_t head_c,
  output logic            full_c,
  output logic            empty_c
);

  localparam int unsigned CNT_W = OUT_FIFO_PTR_W + 1;

  rsz_fifo_entry_t [OUT_FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [OUT_FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      do_push, do_pop;

  assign full_c  = (cnt_q == CNT_W'(OUT_FIFO_DEPTH));
  assign empty_c = (cnt_q == '0);
  assign head_c  = mem_q[rd_ptr_q];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  // Pointer / occupancy update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + OUT_FIFO_PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + OUT_FIFO_PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/img_rsz.sv
// Streaming block-averaging image down-scaler to an 8x4 output image.
//  Clk/Reset            : clock, async active-high reset
//  ImgWidth/ImgHeight   : input frame size (stable per frame)
//  PxlData/PxlX/PxlY    : input pixel and its coordinates; PxlVld/PxlRdy handshake
//  RszPxlData/X/Y       : resized pixel (FIFO head); RszPxlVld/RszPxlRdy handshake
//  FcRszPxlBuf          : live block accumulators (raw sums)
//  RszPxlParVld         : per-block completion flags for the current frame
module img_rsz
  import ImgRszPkg::*;
(
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic [IMG_WIDTH_IDX_W-1:0]       ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]      ImgHeight,
  input  logic [PXL_PRIM_COLOR_W-1:0]      PxlData [PXL_PRIM_COLOR_NUM],
  input  logic [IMG_WIDTH_IDX_W-1:0]       PxlX,
  input  logic [IMG_HEIGHT_IDX_W-1:0]      PxlY,
  input  logic                             PxlVld,
  output logic                             PxlRdy,
  output FcRszPxlData_t                    RszPxlData,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]   RszPxlX,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0]  RszPxlY,
  output logic                             RszPxlVld,
  input  logic                             RszPxlRdy,
  output FcRszPxlBuf_t                     FcRszPxlBuf,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] RszPxlParVld
);

  FcRszPxlBuf_t acc_q, acc_d;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] par_vld_q, par_vld_d;

  logic [RSZ_SHIFT_W-1:0]          kx, ky;
  logic [RSZ_SHIFT_W:0]            avg_shift;
  logic [IMG_WIDTH_IDX_W-1:0]      bx_full, mask_x;
  logic [IMG_HEIGHT_IDX_W-1:0]     by_full, mask_y;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  bx;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] by;
  logic in_range, accept, frame_start, block_last;
  logic fifo_full, fifo_empty, push;
  rsz_fifo_entry_t push_entry, head;

  // Block geometry derived from the frame size.
  assign kx        = blk_shift(ImgWidth, RSZ_SHIFT_W'(RSZ_IMG_WIDTH_IDX_W));
  assign ky        = blk_shift(ImgHeight, RSZ_SHIFT_W'(RSZ_IMG_HEIGHT_IDX_W));
  assign avg_shift = {1'b0, kx} + {1'b0, ky};
  assign bx_full   = PxlX >> kx;
  assign by_full   = PxlY >> ky;
  assign bx        = bx_full[RSZ_IMG_WIDTH_IDX_W-1:0];
  assign by        = by_full[RSZ_IMG_HEIGHT_IDX_W-1:0];
  assign mask_x    = (IMG_WIDTH_IDX_W'(1) << kx) - IMG_WIDTH_IDX_W'(1);
  assign mask_y    = (IMG_HEIGHT_IDX_W'(1) << ky) - IMG_HEIGHT_IDX_W'(1);

  // Out-of-image or out-of-grid pixels are consumed but contribute nothing.
  assign in_range    = (bx_full < IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE)) &&
                       (by_full < IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE)) &&
                       (PxlX < ImgWidth) && (PxlY < ImgHeight);
  assign block_last  = ((PxlX & mask_x) == mask_x) && ((PxlY & mask_y) == mask_y);
  assign PxlRdy      = ~Reset & ~fifo_full;
  assign accept      = PxlVld & PxlRdy;
  assign frame_start = accept && (PxlX == '0) && (PxlY == '0);

  // Accumulate; a frame start zeroes every block before its own pixel is added.
  always_comb begin
    acc_d      = frame_start ? '0 : acc_q;
    par_vld_d  = frame_start ? '0 : par_vld_q;
    push       = 1'b0;
    push_entry = '0;
    if (accept && in_range) begin
      for (int c = 0; c < int'(PXL_PRIM_COLOR_NUM); c++) begin
        acc_d[by][bx][c] = acc_d[by][bx][c] + RSZ_ACC_W'(PxlData[c]);
      end
      if (block_last) begin
        par_vld_d[by][bx] = 1'b1;
        push              = 1'b1;
        push_entry.x      = bx;
        push_entry.y      = by;
        for (int c = 0; c < int'(PXL_PRIM_COLOR_NUM); c++) begin
          push_entry.data[c] = PXL_PRIM_COLOR_W'(acc_d[by][bx][c] >> avg_shift);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q     <= '0;
      par_vld_q <= '0;
    end else begin
      acc_q     <= acc_d;
      par_vld_q <= par_vld_d;
    end
  end

  img_rsz_fifo u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (RszPxlRdy),
    .head_c   (head),
    .full_c   (fifo_full),
    .empty_c  (fifo_empty)
  );

  // Output shows the FIFO head, forced to zero when nothing is queued.
  assign RszPxlVld    = ~fifo_empty;
  assign RszPxlData   = fifo_empty ? '0 : head.data;
  assign RszPxlX      = fifo_empty ? '0 : head.x;
  assign RszPxlY      = fifo_empty ? '0 : head.y;
  assign FcRszPxlBuf  = acc_q;
  assign RszPxlParVld = par_vld_q;

endmodule

// File: tb/tb_img_rsz.sv
// Bench for img_rsz: frames are generated in the bench, block means are
// computed directly from the frame arrays and compared with the output stream.
module tb_img_rsz;
  import ImgRszPkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] img_w, img_h, pxl_x, pxl_y;
  logic [7:0]  pxl_data [3];
  logic        pxl_vld, pxl_rdy, rsz_vld, rsz_rdy;
  FcRszPxlData_t rsz_data;
  logic [2:0]  rsz_x;
  logic [1:0]  rsz_y;
  FcRszPxlBuf_t buf_obs;
  logic [3:0][7:0] par_vld;

  always #5 clk = ~clk;

  img_rsz dut (
    .Clk(clk), .Reset(rst), .ImgWidth(img_w), .ImgHeight(img_h),
    .PxlData(pxl_data), .PxlX(pxl_x), .PxlY(pxl_y), .PxlVld(pxl_vld), .PxlRdy(pxl_rdy),
    .RszPxlData(rsz_data), .RszPxlX(rsz_x), .RszPxlY(rsz_y), .RszPxlVld(rsz_vld),
    .RszPxlRdy(rsz_rdy), .FcRszPxlBuf(buf_obs), .RszPxlParVld(par_vld)
  );

  typedef struct packed { logic [10:0] x; logic [10:0] y; logic [2:0][7:0] d; } pix_t;
  typedef struct packed { logic [2:0] x; logic [1:0] y; logic [2:0][7:0] d; } out_t;

  pix_t         frame_q[$];
  out_t         exp_q[$];
  FcRszPxlBuf_t exp_buf;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_buf(input string tag, input FcRszPxlBuf_t exp);
    for (int by = 0; by < 4; by++)
      for (int bx = 0; bx < 8; bx++)
        for (int c = 0; c < 3; c++)
          check($sformatf("%s[%0d][%0d][%0d]", tag, by, bx, c),
                64'(buf_obs[by][bx][c]), 64'(exp[by][bx][c]));
  endtask

  function automatic int flog2(input int v);
    int l = 0;
    while ((2 << l) <= v) l++;
    return l;
  endfunction

  // mode 0: ramp ch0 = x; 1: all channels = val; 2: random
  task automatic build_frame(input int w, input int h, input int mode, input int val);
    pix_t p;
    out_t o;
    int kx, ky, bw, bh;
    longint sum;
    img_w = 11'(w);
    img_h = 11'(h);
    frame_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        p.x = 11'(x);
        p.y = 11'(y);
        for (int c = 0; c < 3; c++)
          p.d[c] = (mode == 0) ? ((c == 0) ? 8'(x) : 8'd0) :
                   (mode == 1) ? 8'(val) : 8'($urandom);
        frame_q.push_back(p);
      end
    kx = flog2(w) - 3; if (kx < 0) kx = 0;
    ky = flog2(h) - 2; if (ky < 0) ky = 0;
    bw = 1 << kx;
    bh = 1 << ky;
    exp_q.delete();
    exp_buf = '0;
    for (int by = 0; by < 4; by++)
      for (int bx = 0; bx < 8; bx++) begin
        o.x = 3'(bx);
        o.y = 2'(by);
        for (int c = 0; c < 3; c++) begin
          sum = 0;
          for (int yy = 0; yy < bh; yy++)
            for (int xx = 0; xx < bw; xx++)
              sum += longint'(frame_q[(by * bh + yy) * w + bx * bw + xx].d[c]);
          exp_buf[by][bx][c] = 30'(sum);
          o.d[c] = 8'(sum / (bw * bh));
        end
        exp_q.push_back(o);
      end
  endtask

  task automatic run_frame(input int stall_idx, input bit rand_rdy, input bit lat_chk,
                           input bit chk_first);
    int idx, cyc, n;
    bit hold, first_done;
    int lat_q[$];
    out_t e;
    FcRszPxlBuf_t first_buf;
    idx = 0; cyc = 0; n = frame_q.size();
    hold = (stall_idx > 0);
    first_done = 1'b0;
    while ((idx < n || exp_q.size() > 0) && cyc < 30000) begin
      @(negedge clk);
      if (chk_first && idx == 1 && !first_done) begin
        first_done = 1'b1;
        first_buf = '0;
        for (int c = 0; c < 3; c++) first_buf[0][0][c] = 30'(frame_q[0].d[c]);
        check("first_pix_parvld", 64'(par_vld), 64'd0);
        check_buf("first_pix_buf", first_buf);
      end
      pxl_vld = (idx < n);
      if (idx < n) begin
        pxl_x = frame_q[idx].x;
        pxl_y = frame_q[idx].y;
        for (int c = 0; c < 3; c++) pxl_data[c] = frame_q[idx].d[c];
      end
      rsz_rdy = hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      if (hold && !pxl_rdy) begin
        check("stall_accepted", 64'(idx), 64'(stall_idx));
        check("stall_out_vld", 64'(rsz_vld), 64'd1);
        hold = 1'b0;
      end
      if (rsz_vld && rsz_rdy) begin
        check("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_x", 64'(rsz_x), 64'(e.x));
          check("out_y", 64'(rsz_y), 64'(e.y));
          check($sformatf("out_data(%0d,%0d)", e.x, e.y), 64'(rsz_data), 64'(e.d));
          if (lat_chk) begin
            check("lat_pending", 64'(lat_q.size() > 0), 64'd1);
            if (lat_q.size() > 0) check("latency", 64'(cyc), 64'(lat_q.pop_front() + 1));
          end
        end
      end
      if (pxl_vld && pxl_rdy) begin
        if (lat_chk) lat_q.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    pxl_vld = 1'b0;
    rsz_rdy = 1'b1;
    #1;
    check("frame_complete", 64'(idx == n && exp_q.size() == 0), 64'd1);
    check("drained", 64'(rsz_vld), 64'd0);
    check("parvld_all", 64'(par_vld), 64'hFFFF_FFFF);
    check_buf("end_buf", exp_buf);
  endtask

  initial begin
    int idx;
    rst = 1'b1; pxl_vld = 1'b0; rsz_rdy = 1'b0;
    pxl_x = '0; pxl_y = '0; img_w = 11'd8; img_h = 11'd4;
    for (int c = 0; c < 3; c++) pxl_data[c] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_pxl_rdy", 64'(pxl_rdy), 64'd0);
    check("rst_out_vld", 64'(rsz_vld), 64'd0);
    check("rst_parvld", 64'(par_vld), 64'd0);
    check("rst_buf_zero", 64'(buf_obs === '0), 64'd1);
    check("rst_out_data", 64'(rsz_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp 128x64 with downstream held off until the FIFO fills after 8 blocks
    build_frame(128, 64, 0, 0);
    run_frame(2048, 1'b0, 1'b0, 1'b0);

    // Constant 8x4: single-pixel blocks, one-cycle latency
    build_frame(8, 4, 1, 200);
    run_frame(0, 1'b0, 1'b1, 1'b0);

    // Second frame 16x8: (0,0) wipes prior sums and flags
    build_frame(16, 8, 1, 10);
    run_frame(0, 1'b0, 1'b0, 1'b1);

    // Random data, random downstream ready
    build_frame(64, 32, 2, 0);
    run_frame(0, 1'b1, 1'b0, 1'b1);

    // Non-power-of-two: out-of-grid pixels must be discarded
    build_frame(12, 6, 2, 0);
    run_frame(0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a frame with the FIFO full
    build_frame(8, 4, 2, 0);
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pxl_vld = 1'b1;
      pxl_x = frame_q[idx].x;
      pxl_y = frame_q[idx].y;
      for (int c = 0; c < 3; c++) pxl_data[c] = frame_q[idx].d[c];
      rsz_rdy = 1'b0;
      #1;
      if (pxl_vld && pxl_rdy) idx++;
    end
    check("pre_rst_full", 64'(pxl_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pxl_vld = 1'b0;
    #1;
    check("midrst_out_vld", 64'(rsz_vld), 64'd0);
    check("midrst_pxl_rdy", 64'(pxl_rdy), 64'd0);
    check("midrst_parvld", 64'(par_vld), 64'd0);
    check("midrst_buf_zero", 64'(buf_obs === '0), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    build_frame(8, 4, 2, 0);
    run_frame(0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
